adder_operand_loader: RTL and testbench
=======================================

Name: adder_operand_loader

Overview:
Upstream feeder for the parameterised wide adder. It assembles two W-bit operands A and B from an 8-bit byte stream, least-significant byte first, using a valid/ready handshake. It captures the carry-in with the last byte of B. It then presents A, B and C_in, stable and with a valid/ready handshake, to the adder stage for as long as that stage needs them.

Parameters:
W, 128, operand width in bits; must be a multiple of 8 and at least 16.
NB, W/8, bytes per operand (derived; not overridden).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous abort; discards any partial or held operation.
in_data  input  8  operand byte.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader accepts a byte this cycle.
in_cin  input  1  carry-in; sampled only with the last byte of B.
out_A  output  W  assembled operand A to the adder.
out_B  output  W  assembled operand B to the adder.
out_C_in  output  1  carry-in to the adder.
out_valid  output  1  out_A, out_B and out_C_in form a complete operation.
out_ready  input  1  downstream consumes the operation this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=LOAD_A, byte counter cnt=0.
  - out_A=0, out_B=0, out_C_in=0, out_valid=0.
  - in_ready=1 as soon as the reset clears.
- Byte counter: cnt is clog2(NB) bits wide and ranges 0..NB-1.
- Byte acceptance (accept = in_valid & in_ready):
  - The accepted byte is written to byte lane cnt of the active operand: bits [cnt*8+7 : cnt*8].
- in_ready is decoded from registered state only:
  - 1 in LOAD_A and LOAD_B.
  - 0 in HOLD.
  - No combinational path from out_ready.
- State LOAD_A:
  - Each accept writes into out_A and increments cnt.
  - On an accept with cnt==NB-1: cnt wraps to 0, next state LOAD_B.
- State LOAD_B:
  - Same as LOAD_A, but writes into out_B.
  - On the accept with cnt==NB-1: out_C_in<=in_cin, cnt<=0, out_valid<=1, next state HOLD.
- State HOLD:
  - out_valid=1; out_A, out_B and out_C_in are held constant.
  - in_valid is ignored; no byte is consumed.
  - When out_ready=1: out_valid<=0, next state LOAD_A. The operand registers keep their values until overwritten.
- out_ready while out_valid=0 has no effect.
- Timing:
  - out_valid rises the cycle after the 2*NB-th accept.
  - Minimum period per operation is 2*NB+1 cycles.
  - Bubbles on in_valid only stretch the load; they never corrupt lane order.
- Contents of out_A and out_B are defined only while out_valid=1. While loading they are partially updated.
- clr=1:
  - state=LOAD_A, cnt=0, out_valid=0, out_A=0, out_B=0, out_C_in=0 at the next edge.
  - clr has priority over accept and over out_ready in the same cycle.
- Simultaneous out_ready and in_valid in HOLD: only the handshake completes. The byte is accepted on a later cycle, once in_ready=1.
- Reset asserted mid-operation (any state): all outputs go to their reset values immediately and the partial operands are discarded.

Test Plan:
1. W=16. Bytes 0x34, 0x12, 0x78, 0x56 on consecutive cycles, in_cin=1 with 0x56, out_ready=1 -> out_valid=1 the cycle after the 4th accept, with A=0x1234, B=0x5678, C_in=1 (adder S=0x68AD, C_out=0). out_valid=0 the following cycle.
2. W=16. Same bytes with 0-3 idle cycles of in_valid=0 between them -> identical A, B and C_in. out_valid asserts exactly one cycle after the 4th accept.
3. W=16. out_ready=0 for 5 cycles in HOLD while in_valid=1 with in_data=0xFF -> in_ready=0, outputs unchanged at 0x1234/0x5678/1. Then raise out_ready -> out_valid=0 next cycle. The next 0xAB is accepted into A[7:0].
4. W=16. Accept 3 bytes, pulse clr with in_valid=1 in the same cycle -> that byte is not taken and out_A=out_B=0. Then 0x01, 0x00, 0x02, 0x00 with in_cin=0 -> A=0x0001, B=0x0002, C_in=0.
5. W=16. Drop rst_n asynchronously mid-LOAD_B -> out_valid, out_A, out_B and out_C_in are 0 before the next clk edge. After release, a full 4-byte load completes normally.
6. W=128. 32 bytes of 0xFF with in_cin=1 -> A=B=all ones, C_in=1, out_valid on cycle 33. The downstream adder gives S=all ones and C_out=1.

Source files
------------

// File: rtl/adder_operand_loader_if.sv
// Bundle between the byte-stream operand loader and its neighbours.
// Carries the upstream byte stream and the downstream operand handshake.
//   in_data/in_valid/in_cin -> loader    in_ready  <- loader
//   out_A/out_B/out_C_in/out_valid <- loader    out_ready -> loader
// slave  : the loader itself
// master : the environment (byte producer plus adder stage)
interface adder_operand_loader_if #(
  parameter int W = 128
);
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_cin;
  logic [W-1:0] out_A;
  logic [W-1:0] out_B;
  logic         out_C_in;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_data, in_valid, in_cin, out_ready,
    output in_ready, out_A, out_B, out_C_in, out_valid
  );

  modport master (
    output in_data, in_valid, in_cin, out_ready,
    input  in_ready, out_A, out_B, out_C_in, out_valid
  );
endinterface

// File: rtl/adder_operand_loader.sv
// Operand loader for the wide adder.
// Assembles W-bit operands A then B from an LSB-first byte stream, captures the
// carry-in with the last byte of B, then holds A/B/C_in with out_valid until
// the adder stage takes them with out_ready.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - synchronous abort of any partial or held operation
//   bus   - slave side of adder_operand_loader_if (byte stream in, operands out)
module adder_operand_loader #(
  parameter int W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  adder_operand_loader_if.slave bus
);

  localparam int NB    = W / 8;
  localparam int CNT_W = $clog2(NB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             cin_q, cin_d;
  logic             vld_q, vld_d;

  logic in_ready_w;
  logic accept;
  logic cnt_last;

  // Ready depends on registered state only, so out_ready never reaches in_ready.
  assign in_ready_w = (state_q != HOLD);
  assign accept     = bus.in_valid & in_ready_w;
  assign cnt_last   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    vld_d   = vld_q;
    if (clr) begin
      // Abort wins over both a byte accept and a downstream handshake.
      state_d = LOAD_A;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      cin_d   = 1'b0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept) begin
            a_d[int'(cnt_q)*8 +: 8] = bus.in_data;
            if (cnt_last) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_d[int'(cnt_q)*8 +: 8] = bus.in_data;
            if (cnt_last) begin
              cin_d   = bus.in_cin;
              cnt_d   = '0;
              vld_d   = 1'b1;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Operands stay in place after the handshake until overwritten.
          if (bus.out_ready) begin
            vld_d   = 1'b0;
            state_d = LOAD_A;
          end
        end
        default: begin
          state_d = LOAD_A;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_A     = a_q;
  assign bus.out_B     = b_q;
  assign bus.out_C_in  = cin_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
module tb_adder_operand_loader;

  logic clk;
  logic rst_n;
  logic clr16;
  logic clr128;

  int n_assert;
  int n_fail;

  logic [16:0]  s16;
  logic [128:0] s128;

  adder_operand_loader_if #(.W(16))  b16  ();
  adder_operand_loader_if #(.W(128)) b128 ();

  adder_operand_loader #(.W(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr16),
    .bus   (b16)
  );

  adder_operand_loader #(.W(128)) dut128 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr128),
    .bus   (b128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send16(input logic [7:0] d, input logic c, input int idle);
    b16.in_valid = 1'b0;
    repeat (idle) step();
    b16.in_valid = 1'b1;
    b16.in_data  = d;
    b16.in_cin   = c;
    step();
    b16.in_valid = 1'b0;
    b16.in_cin   = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr16    = 1'b0;
    clr128   = 1'b0;
    b16.in_data   = 8'h00;
    b16.in_valid  = 1'b0;
    b16.in_cin    = 1'b0;
    b16.out_ready = 1'b0;
    b128.in_data   = 8'h00;
    b128.in_valid  = 1'b0;
    b128.in_cin    = 1'b0;
    b128.out_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_valid", b16.out_valid, 0);
    chk("rst_A", b16.out_A, 0);
    chk("rst_B", b16.out_B, 0);
    chk("rst_cin", b16.out_C_in, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", b16.in_ready, 1);

    // Test 1: back-to-back load
    send16(8'h34, 1'b0, 0);
    send16(8'h12, 1'b0, 0);
    send16(8'h78, 1'b0, 0);
    chk("t1_pre_valid", b16.out_valid, 0);
    b16.out_ready = 1'b1;
    send16(8'h56, 1'b1, 0);
    chk("t1_valid", b16.out_valid, 1);
    chk("t1_A", b16.out_A, 16'h1234);
    chk("t1_B", b16.out_B, 16'h5678);
    chk("t1_cin", b16.out_C_in, 1);
    chk("t1_in_ready_hold", b16.in_ready, 0);
    s16 = 17'(b16.out_A) + 17'(b16.out_B) + 17'(b16.out_C_in);
    chk("t1_sum", s16, 17'h068AD);
    step();
    chk("t1_valid_drop", b16.out_valid, 0);
    chk("t1_in_ready_back", b16.in_ready, 1);

    // Test 2: bubbles between bytes
    b16.out_ready = 1'b0;
    send16(8'h34, 1'b0, 2);
    send16(8'h12, 1'b0, 0);
    send16(8'h78, 1'b0, 3);
    b16.in_valid = 1'b0;
    step();
    chk("t2_pre_valid", b16.out_valid, 0);
    send16(8'h56, 1'b1, 0);
    chk("t2_valid", b16.out_valid, 1);
    chk("t2_A", b16.out_A, 16'h1234);
    chk("t2_B", b16.out_B, 16'h5678);
    chk("t2_cin", b16.out_C_in, 1);

    // Test 3: stall in HOLD with in_valid asserted
    b16.in_valid = 1'b1;
    b16.in_data  = 8'hFF;
    b16.in_cin   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_in_ready", b16.in_ready, 0);
      chk("t3_valid", b16.out_valid, 1);
      chk("t3_A", b16.out_A, 16'h1234);
      chk("t3_B", b16.out_B, 16'h5678);
      chk("t3_cin", b16.out_C_in, 1);
    end
    b16.out_ready = 1'b1;
    b16.in_data   = 8'hAB;
    step();
    chk("t3_valid_drop", b16.out_valid, 0);
    chk("t3_A_not_taken", b16.out_A, 16'h1234);
    chk("t3_in_ready", b16.in_ready, 1);
    b16.out_ready = 1'b0;
    step();
    chk("t3_A_lane0", b16.out_A, 16'h12AB);

    // Test 4: clr mid-load with a byte offered
    b16.in_data = 8'h11;
    step();
    b16.in_data = 8'h22;
    step();
    chk("t4_B_partial", b16.out_B, 16'h5622);
    clr16 = 1'b1;
    b16.in_data = 8'h33;
    step();
    clr16 = 1'b0;
    b16.in_valid = 1'b0;
    chk("t4_clr_A", b16.out_A, 0);
    chk("t4_clr_B", b16.out_B, 0);
    chk("t4_clr_cin", b16.out_C_in, 0);
    chk("t4_clr_valid", b16.out_valid, 0);
    b16.out_ready = 1'b1;
    send16(8'h01, 1'b0, 0);
    send16(8'h00, 1'b0, 0);
    send16(8'h02, 1'b0, 0);
    send16(8'h00, 1'b0, 0);
    chk("t4_valid", b16.out_valid, 1);
    chk("t4_A", b16.out_A, 16'h0001);
    chk("t4_B", b16.out_B, 16'h0002);
    chk("t4_cin", b16.out_C_in, 0);
    step();
    chk("t4_valid_drop", b16.out_valid, 0);

    // Test 5: asynchronous reset during LOAD_B
    b16.out_ready = 1'b0;
    send16(8'h34, 1'b0, 0);
    send16(8'h12, 1'b0, 0);
    send16(8'h78, 1'b0, 0);
    chk("t5_B_partial", b16.out_B, 16'h0078);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_A", b16.out_A, 0);
    chk("t5_async_B", b16.out_B, 0);
    chk("t5_async_cin", b16.out_C_in, 0);
    chk("t5_async_valid", b16.out_valid, 0);
    #2;
    rst_n = 1'b1;
    chk("t5_in_ready", b16.in_ready, 1);
    b16.out_ready = 1'b1;
    send16(8'hCD, 1'b0, 0);
    send16(8'hAB, 1'b0, 0);
    send16(8'hEF, 1'b0, 0);
    send16(8'hBE, 1'b1, 0);
    chk("t5_valid", b16.out_valid, 1);
    chk("t5_A", b16.out_A, 16'hABCD);
    chk("t5_B", b16.out_B, 16'hBEEF);
    chk("t5_cin", b16.out_C_in, 1);
    step();
    chk("t5_valid_drop", b16.out_valid, 0);

    // Test 6: W=128, all ones
    b128.in_valid = 1'b1;
    b128.in_data  = 8'hFF;
    b128.in_cin   = 1'b0;
    repeat (31) step();
    chk("t6_pre_valid", b128.out_valid, 0);
    b128.in_cin = 1'b1;
    step();
    b128.in_valid = 1'b0;
    b128.in_cin   = 1'b0;
    chk("t6_valid", b128.out_valid, 1);
    chk("t6_A", b128.out_A, {1'b0, {128{1'b1}}});
    chk("t6_B", b128.out_B, {1'b0, {128{1'b1}}});
    chk("t6_cin", b128.out_C_in, 1);
    s128 = 129'(b128.out_A) + 129'(b128.out_B) + 129'(b128.out_C_in);
    chk("t6_sum", s128, {129{1'b1}});
    b128.out_ready = 1'b1;
    step();
    chk("t6_valid_drop", b128.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
